// File: rtl/cu_pkg.sv
// Shared definitions for the microcoded control unit: state and branch
// encodings, default geometry and the microword field layout.
package cu_pkg;

    // Default geometry of the datapath control fields and microcode store.
    localparam int DEF_DW    = 8;
    localparam int DEF_IMW   = 3;
    localparam int DEF_RW    = 4;
    localparam int DEF_OMW   = 4;
    localparam int DEF_IW    = 2;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = $clog2(DEF_DEPTH);
    localparam int DEF_UW    = 1 + DEF_DW + DEF_IMW + DEF_RW + DEF_OMW + DEF_IW + 2 + DEF_AW + 1;

    // Microword field offsets at the default geometry, LSB first.
    localparam int F_WE     = 0;
    localparam int F_CONST  = 1;
    localparam int F_INMUX  = F_CONST + DEF_DW;
    localparam int F_REG    = F_INMUX + DEF_IMW;
    localparam int F_OUTMUX = F_REG + DEF_RW;
    localparam int F_INS    = F_OUTMUX + DEF_OMW;
    localparam int F_COND   = F_INS + DEF_IW;
    localparam int F_NEXT   = F_COND + 2;
    localparam int F_END    = F_NEXT + DEF_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        COND_SEQ = 2'd0,
        COND_JMP = 2'd1,
        COND_JC  = 2'd2,
        COND_JZ  = 2'd3
    } cond_e;

endpackage

// File: rtl/ucode_store.sv
// Microcode store: register array with a synchronous write port and an
// asynchronous read port addressed by the microprogram counter.
module ucode_store #(
    parameter int DEPTH = 16,
    parameter int UW    = 29,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [UW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [UW-1:0] rd_data
);

    logic [UW-1:0] mem [DEPTH];

    // Host writes land at the clock edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ucode_cu.sv
// Microcoded datapath control unit. Sequences control words out of a
// host-loadable store, with flag-conditional branching, busy stalls,
// abort and a one-cycle done pulse at program end.
module ucode_cu
    import cu_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int IMW   = DEF_IMW,
    parameter int RW    = DEF_RW,
    parameter int OMW   = DEF_OMW,
    parameter int IW    = DEF_IW,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int UW   = 1 + DW + IMW + RW + OMW + IW + 2 + AW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           busy,
    input  logic           c0,
    input  logic           z,
    input  logic           prog_we,
    input  logic [AW-1:0]  prog_addr,
    input  logic [UW-1:0]  prog_data,
    output logic           we,
    output logic [DW-1:0]  cu_const,
    output logic [IMW-1:0] in_mux_add,
    output logic [RW-1:0]  reg_add,
    output logic [OMW-1:0] out_mux_add,
    output logic [IW-1:0]  ins_sel,
    output logic           active,
    output logic           done,
    output logic [AW-1:0]  upc
);

    // Field layout for this instance's geometry.
    localparam int L_CONST  = 1;
    localparam int L_INMUX  = L_CONST + DW;
    localparam int L_REG    = L_INMUX + IMW;
    localparam int L_OUTMUX = L_REG + RW;
    localparam int L_INS    = L_OUTMUX + OMW;
    localparam int L_COND   = L_INS + IW;
    localparam int L_NEXT   = L_COND + 2;
    localparam int L_END    = L_NEXT + AW;

    state_e         state_q, state_d;
    logic [AW-1:0]  upc_q, upc_d;
    logic           we_q, we_d;
    logic [DW-1:0]  const_q, const_d;
    logic [IMW-1:0] inmux_q, inmux_d;
    logic [RW-1:0]  reg_q, reg_d;
    logic [OMW-1:0] outmux_q, outmux_d;
    logic [IW-1:0]  ins_q, ins_d;
    logic           active_q, active_d;
    logic           done_q, done_d;

    logic           mem_we;
    logic [UW-1:0]  uword;
    cond_e          cond;

    ucode_store #(.DEPTH(DEPTH), .UW(UW), .AW(AW)) u_store (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (upc_q),
        .rd_data (uword)
    );

    assign cond = cond_e'(uword[L_COND +: 2]);

    // Next state, next upc and next control outputs; we and done are pulses.
    always_comb begin
        state_d  = state_q;
        upc_d    = upc_q;
        we_d     = 1'b0;
        const_d  = const_q;
        inmux_d  = inmux_q;
        reg_d    = reg_q;
        outmux_d = outmux_q;
        ins_d    = ins_q;
        active_d = active_q;
        done_d   = 1'b0;
        mem_we   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The store is only writable while no program is running.
                mem_we = prog_we;
                if (start) begin
                    upc_d    = '0;
                    active_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (!busy) begin
                    we_d     = uword[0];
                    const_d  = uword[L_CONST +: DW];
                    inmux_d  = uword[L_INMUX +: IMW];
                    reg_d    = uword[L_REG +: RW];
                    outmux_d = uword[L_OUTMUX +: OMW];
                    ins_d    = uword[L_INS +: IW];
                    if (uword[L_END]) begin
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        unique case (cond)
                            COND_SEQ: upc_d = upc_q + AW'(1);
                            COND_JMP: upc_d = uword[L_NEXT +: AW];
                            COND_JC:  upc_d = c0 ? uword[L_NEXT +: AW] : upc_q + AW'(1);
                            COND_JZ:  upc_d = z  ? uword[L_NEXT +: AW] : upc_q + AW'(1);
                        endcase
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            upc_q    <= '0;
            we_q     <= 1'b0;
            const_q  <= '1;
            inmux_q  <= '0;
            reg_q    <= RW'(1);
            outmux_q <= '0;
            ins_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            upc_q    <= upc_d;
            we_q     <= we_d;
            const_q  <= const_d;
            inmux_q  <= inmux_d;
            reg_q    <= reg_d;
            outmux_q <= outmux_d;
            ins_q    <= ins_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign we          = we_q;
    assign cu_const    = const_q;
    assign in_mux_add  = inmux_q;
    assign reg_add     = reg_q;
    assign out_mux_add = outmux_q;
    assign ins_sel     = ins_q;
    assign active      = active_q;
    assign done        = done_q;
    assign upc         = upc_q;

endmodule
